// File: rtl/req_pending_arb.sv
// rtl/req_pending_arb.sv - sticky edge-triggered request collector with MSB-first single-grant arbiter
module req_pending_arb #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_in,
    input  logic [N-1:0]    mask,
    input  logic            hold,
    input  logic            rdy,
    input  logic            clr_ovf,
    output logic            vld,
    output logic [IDXW-1:0] idx,
    output logic [N-1:0]    pend,
    output logic            ovf
);

    logic [N-1:0]    req_q,  req_d;
    logic [N-1:0]    pend_q, pend_d;
    logic            vld_q,  vld_d;
    logic [IDXW-1:0] idx_q,  idx_d;
    logic            ovf_q,  ovf_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    cand;
    logic [N-1:0]    grant_vec;
    logic [N-1:0]    lost;
    logic [IDXW-1:0] pick;
    logic            slot_free;
    logic            grant;

    always_comb begin
        req_d     = req_in;
        rise      = req_in & ~req_q;
        // Only registered pending bits compete; this cycle's edges wait one clock.
        cand      = pend_q & ~mask;
        slot_free = ~vld_q | rdy;

        // Ascending scan so the highest set bit is the last one written.
        pick = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                pick = IDXW'(i);
            end
        end

        grant     = slot_free & ~hold & (|cand);
        grant_vec = '0;
        if (grant) begin
            grant_vec[pick] = 1'b1;
        end

        // A new edge on the bit being granted re-arms it rather than being lost.
        lost   = rise & pend_q & ~grant_vec;
        pend_d = (pend_q & ~grant_vec) | rise;

        ovf_d = ovf_q;
        if (|lost) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        vld_d = vld_q;
        idx_d = idx_q;
        if (slot_free) begin
            vld_d = grant;
            if (grant) begin
                idx_d = pick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            pend_q <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            req_q  <= req_d;
            pend_q <= pend_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            ovf_q  <= ovf_d;
        end
    end

    assign vld  = vld_q;
    assign idx  = idx_q;
    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_req_pending_arb.sv
// tb/tb_req_pending_arb.sv - directed self-checking bench for req_pending_arb
module tb_req_pending_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       hold;
    logic       rdy;
    logic       clr_ovf;
    logic       vld;
    logic [1:0] idx;
    logic [3:0] pend;
    logic       ovf;
    logic [7:0] st;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Observed status word: {vld, idx[1:0], pend[3:0], ovf}
    assign st = {vld, idx, pend, ovf};

    req_pending_arb #(.N(4), .IDXW(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .mask    (mask),
        .hold    (hold),
        .rdy     (rdy),
        .clr_ovf (clr_ovf),
        .vld     (vld),
        .idx     (idx),
        .pend    (pend),
        .ovf     (ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 4'b0000; mask = 4'b0000; hold = 1'b0; rdy = 1'b1; clr_ovf = 1'b0;
        step(); step();
        checks++;
        if (st !== 8'b0_00_0000_0) begin failures++; $display("FAIL reset_state got=%b exp=%b", st, 8'b0_00_0000_0); end
        rst = 1'b0;
        step();
        checks++;
        if (st !== 8'b0_00_0000_0) begin failures++; $display("FAIL reset_idle got=%b exp=%b", st, 8'b0_00_0000_0); end
    endtask

    task automatic test_single();
        req_in = 4'b0100; rdy = 1'b1;
        step();
        checks++;
        if (st !== 8'b0_00_0100_0) begin failures++; $display("FAIL single_pend got=%b exp=%b", st, 8'b0_00_0100_0); end
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_10_0000_0) begin failures++; $display("FAIL single_grant got=%b exp=%b", st, 8'b1_10_0000_0); end
        step();
        checks++;
        if (st !== 8'b0_10_0000_0) begin failures++; $display("FAIL single_idle got=%b exp=%b", st, 8'b0_10_0000_0); end
    endtask

    task automatic test_back_to_back();
        req_in = 4'b1011;
        step();
        checks++;
        if (st !== 8'b0_10_1011_0) begin failures++; $display("FAIL b2b_pend got=%b exp=%b", st, 8'b0_10_1011_0); end
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_11_0011_0) begin failures++; $display("FAIL b2b_g3 got=%b exp=%b", st, 8'b1_11_0011_0); end
        step();
        checks++;
        if (st !== 8'b1_01_0001_0) begin failures++; $display("FAIL b2b_g1 got=%b exp=%b", st, 8'b1_01_0001_0); end
        step();
        checks++;
        if (st !== 8'b1_00_0000_0) begin failures++; $display("FAIL b2b_g0 got=%b exp=%b", st, 8'b1_00_0000_0); end
        step();
        checks++;
        if (st !== 8'b0_00_0000_0) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", st, 8'b0_00_0000_0); end
    endtask

    task automatic test_stall();
        logic [3:0] req_seq  = 4'b0000;
        logic [4:0] hold_seq = 5'b10101;
        rdy = 1'b0; req_in = 4'b1000;
        step();
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_11_0000_0) begin failures++; $display("FAIL stall_grant got=%b exp=%b", st, 8'b1_11_0000_0); end
        for (int c = 0; c < 5; c++) begin
            req_seq = (c == 0) ? 4'b0001 : 4'b0000;
            req_in  = req_seq;
            hold    = hold_seq[c];
            step();
            checks++;
            if (st !== 8'b1_11_0001_0) begin failures++; $display("FAIL stall_hold%0d got=%b exp=%b", c, st, 8'b1_11_0001_0); end
        end
        hold = 1'b0; rdy = 1'b1;
        step();
        checks++;
        if (st !== 8'b1_00_0000_0) begin failures++; $display("FAIL stall_release got=%b exp=%b", st, 8'b1_00_0000_0); end
        step();
        checks++;
        if (st !== 8'b0_00_0000_0) begin failures++; $display("FAIL stall_idle got=%b exp=%b", st, 8'b0_00_0000_0); end
    endtask

    task automatic test_mask();
        mask = 4'b1000; req_in = 4'b1001;
        step();
        checks++;
        if (st !== 8'b0_00_1001_0) begin failures++; $display("FAIL mask_pend got=%b exp=%b", st, 8'b0_00_1001_0); end
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_00_1000_0) begin failures++; $display("FAIL mask_g0 got=%b exp=%b", st, 8'b1_00_1000_0); end
        step();
        checks++;
        if (st !== 8'b0_00_1000_0) begin failures++; $display("FAIL mask_blocked got=%b exp=%b", st, 8'b0_00_1000_0); end
        mask = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_11_0000_0) begin failures++; $display("FAIL mask_g3 got=%b exp=%b", st, 8'b1_11_0000_0); end
        step();
        checks++;
        if (st !== 8'b0_11_0000_0) begin failures++; $display("FAIL mask_idle got=%b exp=%b", st, 8'b0_11_0000_0); end
    endtask

    task automatic test_overflow();
        hold = 1'b1; req_in = 4'b0010;
        step();
        checks++;
        if (st !== 8'b0_11_0010_0) begin failures++; $display("FAIL ovf_pend got=%b exp=%b", st, 8'b0_11_0010_0); end
        req_in = 4'b0000;
        step();
        req_in = 4'b0010;
        step();
        checks++;
        if (st !== 8'b0_11_0010_1) begin failures++; $display("FAIL ovf_set got=%b exp=%b", st, 8'b0_11_0010_1); end
        req_in = 4'b0000; clr_ovf = 1'b1;
        step();
        checks++;
        if (st !== 8'b0_11_0010_0) begin failures++; $display("FAIL ovf_clear got=%b exp=%b", st, 8'b0_11_0010_0); end
        req_in = 4'b0010;
        step();
        checks++;
        if (st !== 8'b0_11_0010_1) begin failures++; $display("FAIL ovf_clr_vs_lost got=%b exp=%b", st, 8'b0_11_0010_1); end
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b0_11_0010_0) begin failures++; $display("FAIL ovf_reclear got=%b exp=%b", st, 8'b0_11_0010_0); end
        clr_ovf = 1'b0; hold = 1'b0; req_in = 4'b0010;
        step();
        checks++;
        if (st !== 8'b1_01_0010_0) begin failures++; $display("FAIL rearm_grant got=%b exp=%b", st, 8'b1_01_0010_0); end
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_01_0000_0) begin failures++; $display("FAIL rearm_regrant got=%b exp=%b", st, 8'b1_01_0000_0); end
        step();
        checks++;
        if (st !== 8'b0_01_0000_0) begin failures++; $display("FAIL rearm_idle got=%b exp=%b", st, 8'b0_01_0000_0); end
    endtask

    task automatic test_reset_midop();
        rdy = 1'b0; req_in = 4'b1110;
        step();
        req_in = 4'b0000;
        step();
        checks++;
        if (st !== 8'b1_11_0110_0) begin failures++; $display("FAIL midrst_pre got=%b exp=%b", st, 8'b1_11_0110_0); end
        rst = 1'b1;
        step();
        checks++;
        if (st !== 8'b0_00_0000_0) begin failures++; $display("FAIL midrst_clear got=%b exp=%b", st, 8'b0_00_0000_0); end
        req_in = 4'b0001; rdy = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (st !== 8'b0_00_0001_0) begin failures++; $display("FAIL midrst_edge got=%b exp=%b", st, 8'b0_00_0001_0); end
        step();
        checks++;
        if (st !== 8'b1_00_0000_0) begin failures++; $display("FAIL midrst_grant got=%b exp=%b", st, 8'b1_00_0000_0); end
        step();
        checks++;
        if (st !== 8'b0_00_0000_0) begin failures++; $display("FAIL midrst_noretrig got=%b exp=%b", st, 8'b0_00_0000_0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_mask();
        test_overflow();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
